// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 types, round constants, initial hash value and round functions.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [0:7] state_t;
    typedef word_t [0:63] sched_t;

    localparam state_t H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam sched_t K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  state_t s_in,
    input  word_t  k,
    input  word_t  w,
    output state_t s_out
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = s_in[7] + big_sigma1(s_in[4]) + ch(s_in[4], s_in[5], s_in[6]) + k + w;
        t2 = big_sigma0(s_in[0]) + maj(s_in[0], s_in[1], s_in[2]);
        s_out = {t1 + t2, s_in[0], s_in[1], s_in[2], s_in[3] + t1, s_in[4], s_in[5], s_in[6]};
    end

endmodule

// File: rtl/sha256_pipe.sv
// rtl/sha256_pipe.sv - fully unrolled 64-stage SHA-256 compression pipeline, one block per clock.
// SHA256_PIPE_DEBUG_EN adds the 'test' port with the pre-feed-forward working variables.
module sha256_pipe
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [0:7][31:0]   H_in,
    input  logic [0:63][31:0]  W,
    output logic [0:255]       H_out,
    output logic               done
`ifdef SHA256_PIPE_DEBUG_EN
    ,
    output logic [255:0]       test
`endif
);

    // Inputs land in a register first so round 0 starts from a flop, not from the ports.
    state_t in_h_q, in_h_d;
    sched_t in_w_q, in_w_d;
    logic   in_v_q, in_v_d;

    state_t wv_q  [ROUNDS];
    state_t wv_d  [ROUNDS];
    state_t hin_q [ROUNDS];
    state_t hin_d [ROUNDS];
    logic   v_q   [ROUNDS];
    logic   v_d   [ROUNDS];
    // Schedule is shifted one word per stage, so word 0 is always the next round's W.
    sched_t w_q   [ROUNDS-1];
    sched_t w_d   [ROUNDS-1];

    state_t rnd_in  [ROUNDS];
    word_t  rnd_w   [ROUNDS];
    state_t rnd_out [ROUNDS];

    state_t h_out_q, h_out_d;
    logic   done_q, done_d;
    state_t test_q, test_d;

    for (genvar t = 0; t < ROUNDS; t++) begin : g_round
        sha256_round u_round (
            .s_in  (rnd_in[t]),
            .k     (K[t]),
            .w     (rnd_w[t]),
            .s_out (rnd_out[t])
        );
    end

    always_comb begin
        in_h_d = H_in;
        in_w_d = W;
        in_v_d = 1'b1;

        rnd_in[0] = in_h_q;
        rnd_w[0]  = in_w_q[0];
        hin_d[0]  = in_h_q;
        v_d[0]    = in_v_q;
        w_d[0]    = in_w_q << 32;
        for (int t = 1; t < ROUNDS; t++) begin
            rnd_in[t] = wv_q[t-1];
            rnd_w[t]  = w_q[t-1][0];
            hin_d[t]  = hin_q[t-1];
            v_d[t]    = v_q[t-1];
        end
        for (int t = 1; t < ROUNDS - 1; t++) begin
            w_d[t] = w_q[t-1] << 32;
        end
        for (int t = 0; t < ROUNDS; t++) begin
            wv_d[t] = rnd_out[t];
        end

        for (int i = 0; i < 8; i++) begin
            h_out_d[i] = hin_q[ROUNDS-1][i] + wv_q[ROUNDS-1][i];
        end
        done_d = v_q[ROUNDS-1];
        test_d = wv_q[ROUNDS-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_h_q  <= '0;
            in_w_q  <= '0;
            in_v_q  <= 1'b0;
            for (int t = 0; t < ROUNDS; t++) begin
                wv_q[t]  <= '0;
                hin_q[t] <= '0;
                v_q[t]   <= 1'b0;
            end
            for (int t = 0; t < ROUNDS - 1; t++) begin
                w_q[t] <= '0;
            end
            h_out_q <= '0;
            done_q  <= 1'b0;
            test_q  <= '0;
        end else begin
            in_h_q  <= in_h_d;
            in_w_q  <= in_w_d;
            in_v_q  <= in_v_d;
            for (int t = 0; t < ROUNDS; t++) begin
                wv_q[t]  <= wv_d[t];
                hin_q[t] <= hin_d[t];
                v_q[t]   <= v_d[t];
            end
            for (int t = 0; t < ROUNDS - 1; t++) begin
                w_q[t] <= w_d[t];
            end
            h_out_q <= h_out_d;
            done_q  <= done_d;
            test_q  <= test_d;
        end
    end

    assign H_out = h_out_q;
    assign done  = done_q;

`ifdef SHA256_PIPE_DEBUG_EN
    assign test = test_q;
`else
    logic unused_test;
    assign unused_test = ^test_q;
`endif

endmodule

// File: tb/tb_sha256_pipe.sv
// tb/tb_sha256_pipe.sv - self-checking bench for sha256_pipe against a software SHA-256 model.
module tb_sha256_pipe;

    typedef logic [0:7][31:0]  st8_t;
    typedef logic [0:63][31:0] w64_t;
    typedef logic [0:15][31:0] m16_t;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam st8_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam int HIST = 2048;

    logic         clk;
    logic         reset;
    st8_t         h_in;
    w64_t         w_in;
    logic [0:255] h_out;
    logic         done;
`ifdef SHA256_PIPE_DEBUG_EN
    logic [255:0] test;
`endif

    sha256_pipe dut (
        .clk   (clk),
        .reset (reset),
        .H_in  (h_in),
        .W     (w_in),
        .H_out (h_out),
        .done  (done)
`ifdef SHA256_PIPE_DEBUG_EN
        ,
        .test  (test)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic w64_t expand(input m16_t m);
        w64_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        return w;
    endfunction

    // Working variables after all 64 rounds, word 0 (a) in the top bits.
    function automatic logic [255:0] model_rounds(input st8_t hh, input w64_t ww);
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hh[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + ww[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] feed_fwd(input st8_t hh, input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i] + v[255-32*i -: 32];
        return r;
    endfunction

    // Scoreboard: what was sampled at each edge, and when reset was last seen.
    int           cyc = 0;
    int           last_rst = -1000;
    bit           hv  [HIST];
    st8_t         hh  [HIST];
    logic [255:0] hwv [HIST];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST) begin
            if (reset) begin
                last_rst = cyc;
                hv[cyc] = 1'b0;
            end else begin
                hv[cyc]  = 1'b1;
                hh[cyc]  = h_in;
                hwv[cyc] = model_rounds(h_in, w_in);
            end
        end
    end

    always @(negedge clk) begin
        int s;
        bit exp_done;
        if (cyc > 0 && cyc < HIST) begin
            s = cyc - 65;
            exp_done = (s >= 1) && hv[s] && (last_rst < s);
            expect_eq("done", 256'(done), 256'(exp_done));
            if (cyc == last_rst) begin
                expect_eq("h_out_after_reset", h_out, '0);
            end else if (exp_done) begin
                expect_eq("h_out", h_out, feed_fwd(hh[s], hwv[s]));
`ifdef SHA256_PIPE_DEBUG_EN
                expect_eq("test_vars", test, hwv[s]);
`endif
            end
        end
    end

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++) h_in[i] = $urandom();
        for (int i = 0; i < 64; i++) w_in[i] = $urandom();
    endtask

    task automatic wait_done(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        c = cyc;
    endtask

    initial begin
        m16_t m;
        w64_t abc_w, empty_w;
        st8_t ones;
        logic [255:0] wrap_exp;
        int rel, c;

        m = '0;
        m[0] = 32'h61626380;
        m[15] = 32'h00000018;
        abc_w = expand(m);
        m = '0;
        m[0] = 32'h80000000;
        empty_w = expand(m);
        ones = '1;

        reset = 1'b1;
        h_in = IV;
        w_in = abc_w;
        @(negedge clk);
        reset = 1'b0;
        rel = cyc + 1;
        wait_done(c);
        expect_eq("abc_latency", 256'(c - rel), 256'(65));
        expect_eq("abc_digest", h_out, ABC_DIGEST);
`ifdef SHA256_PIPE_DEBUG_EN
        expect_eq("abc_test_plus_iv", feed_fwd(IV, test), h_out);
`endif

        for (int i = 0; i < 150; i++) begin
            rand_inputs();
            @(negedge clk);
        end

        h_in = IV;
        w_in = abc_w;
        @(negedge clk);
        w_in = empty_w;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rand_inputs();
            @(negedge clk);
        end
        expect_eq("b2b_first_done", 256'(done), 256'(1));
        expect_eq("b2b_first_abc", h_out, ABC_DIGEST);
        @(negedge clk);
        expect_eq("b2b_second_done", 256'(done), 256'(1));
        expect_eq("b2b_second_empty", h_out, EMPTY_DIGEST);

        h_in = ones;
        w_in = '0;
        wrap_exp = feed_fwd(ones, model_rounds(ones, '0));
        @(negedge clk);
        for (int i = 0; i < 65; i++) begin
            rand_inputs();
            @(negedge clk);
        end
        expect_eq("wrap_digest", h_out, wrap_exp);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rand_inputs();
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        expect_eq("midrst_done", 256'(done), 256'(0));
        expect_eq("midrst_h_out", h_out, '0);
        reset = 1'b0;
        h_in = IV;
        w_in = empty_w;
        rel = cyc + 1;
        wait_done(c);
        expect_eq("midrst_latency", 256'(c - rel), 256'(65));
        expect_eq("empty_digest", h_out, EMPTY_DIGEST);

        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
